// File: rtl/uart_pkg.sv
// Shared definitions for the 8N1 UART transmitter.
//   BAUD_*      : run-time baud select codes (codes 5..7 fall back to 9600)
//   state_t     : transmitter FSM states
//   bit_period  : clocks per bit for a baud code at a given clock frequency
package uart_pkg;

  localparam logic [2:0] BAUD_9600   = 3'd0;
  localparam logic [2:0] BAUD_19200  = 3'd1;
  localparam logic [2:0] BAUD_38400  = 3'd2;
  localparam logic [2:0] BAUD_57600  = 3'd3;
  localparam logic [2:0] BAUD_115200 = 3'd4;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  // Truncating division, so 50 MHz gives 5208/2604/1302/868/434.
  function automatic logic [31:0] bit_period(input logic [2:0] code,
                                             input int unsigned clk_freq);
    int unsigned rate;
    case (code)
      BAUD_9600:   rate = 9600;
      BAUD_19200:  rate = 19200;
      BAUD_38400:  rate = 38400;
      BAUD_57600:  rate = 57600;
      BAUD_115200: rate = 115200;
      default:     rate = 9600;
    endcase
    return clk_freq / rate;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period divider for the UART transmitter.
//   clk, rst   : system clock, async active-high reset
//   baud_code  : latched baud select code
//   en         : count while high; counter held at zero while low
//   bit_tick   : one-cycle pulse on the last clock of every bit period
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 50_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] baud_code,
  input  logic       en,
  output logic       bit_tick
);

  logic [31:0] period;
  logic [31:0] cnt;

  always_comb begin
    period   = bit_period(baud_code, CLK_FREQ);
    bit_tick = en && (cnt == period - 32'd1);
  end

  // Clearing on the tick itself keeps every bit exactly `period` clocks long.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (!en || bit_tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 32'd1;
    end
  end

endmodule

// File: rtl/uart_sender.sv
// 8N1 UART transmitter: start bit, 8 data bits LSB first, stop bit.
//   Clk, Rst    : system clock, async active-high reset
//   data_byte   : byte to send, latched when a frame starts
//   send_en     : level request, sampled only while idle
//   baud_set    : baud select, latched when a frame starts
//   Rs232_Tx    : serial line, idles high
//   Tx_Done     : one-cycle pulse on the clock after a frame ends
//   uart_state  : high while a frame is on the line
module uart_sender
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 50_000_000
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic [7:0] data_byte,
  input  logic       send_en,
  input  logic [2:0] baud_set,
  output logic       Rs232_Tx,
  output logic       Tx_Done,
  output logic       uart_state
);

  state_t     state, state_next;
  logic [7:0] data_q, data_next;
  logic [2:0] baud_q, baud_next;
  logic [2:0] bit_idx, bit_idx_next;
  logic       tx_next, done_next, busy_next;
  logic       div_en;
  logic       bit_tick;

  assign div_en = (state != IDLE);

  uart_baud_gen #(
    .CLK_FREQ(CLK_FREQ)
  ) u_baud_gen (
    .clk      (Clk),
    .rst      (Rst),
    .baud_code(baud_q),
    .en       (div_en),
    .bit_tick (bit_tick)
  );

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state      <= IDLE;
      data_q     <= '0;
      baud_q     <= '0;
      bit_idx    <= '0;
      Rs232_Tx   <= 1'b1;
      Tx_Done    <= 1'b0;
      uart_state <= 1'b0;
    end else begin
      state      <= state_next;
      data_q     <= data_next;
      baud_q     <= baud_next;
      bit_idx    <= bit_idx_next;
      Rs232_Tx   <= tx_next;
      Tx_Done    <= done_next;
      uart_state <= busy_next;
    end
  end

  // Outputs are computed one cycle ahead and registered, so the line level
  // changes on the same edge as the state transition that selects it.
  always_comb begin
    state_next   = state;
    data_next    = data_q;
    baud_next    = baud_q;
    bit_idx_next = bit_idx;
    tx_next      = Rs232_Tx;
    done_next    = 1'b0;
    busy_next    = uart_state;

    case (state)
      IDLE: begin
        tx_next   = 1'b1;
        busy_next = 1'b0;
        if (send_en) begin
          state_next   = START;
          data_next    = data_byte;
          baud_next    = baud_set;
          bit_idx_next = '0;
          tx_next      = 1'b0;
          busy_next    = 1'b1;
        end
      end
      START: begin
        if (bit_tick) begin
          state_next   = DATA;
          bit_idx_next = '0;
          tx_next      = data_q[0];
        end
      end
      DATA: begin
        if (bit_tick) begin
          if (bit_idx == 3'd7) begin
            state_next = STOP;
            tx_next    = 1'b1;
          end else begin
            bit_idx_next = bit_idx + 3'd1;
            tx_next      = data_q[bit_idx + 3'd1];
          end
        end
      end
      STOP: begin
        if (bit_tick) begin
          state_next = IDLE;
          tx_next    = 1'b1;
          busy_next  = 1'b0;
          done_next  = 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
        tx_next    = 1'b1;
        busy_next  = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_sender.sv
// Self-checking bench for uart_sender: a frame-level reference model
// (position within the frame -> expected line level) compared every cycle,
// plus directed checks on decoded bytes, bit widths and pulse counts.
module tb_uart_sender;

  localparam int unsigned CLK_FREQ = 50_000_000;

  logic       Clk = 1'b0;
  logic       Rst = 1'b1;
  logic [7:0] data_byte = '0;
  logic       send_en = 1'b0;
  logic [2:0] baud_set = '0;
  logic       Rs232_Tx;
  logic       Tx_Done;
  logic       uart_state;

  int checks = 0;
  int errors = 0;
  int cycle = 0;
  int busy_cycles = 0;
  int done_count = 0;

  // Reference model state
  bit         m_active = 1'b0;
  bit         m_done = 1'b0;
  int         m_t = 0;
  int         m_n = 1;
  logic [7:0] m_data = '0;

  uart_sender #(
    .CLK_FREQ(CLK_FREQ)
  ) dut (
    .Clk       (Clk),
    .Rst       (Rst),
    .data_byte (data_byte),
    .send_en   (send_en),
    .baud_set  (baud_set),
    .Rs232_Tx  (Rs232_Tx),
    .Tx_Done   (Tx_Done),
    .uart_state(uart_state)
  );

  always #10 Clk = ~Clk;

  function automatic int model_n(input logic [2:0] code);
    int rate;
    case (code)
      3'd1:    rate = 19200;
      3'd2:    rate = 38400;
      3'd3:    rate = 57600;
      3'd4:    rate = 115200;
      default: rate = 9600;
    endcase
    return CLK_FREQ / rate;
  endfunction

  // Frame of 10*N clocks from the start edge; done flagged on the closing edge.
  always @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      m_active <= 1'b0;
      m_done   <= 1'b0;
      m_t      <= 0;
    end else if (m_active) begin
      if (m_t == 10 * m_n - 1) begin
        m_active <= 1'b0;
        m_done   <= 1'b1;
      end else begin
        m_t    <= m_t + 1;
        m_done <= 1'b0;
      end
    end else begin
      m_done <= 1'b0;
      if (send_en) begin
        m_active <= 1'b1;
        m_t      <= 0;
        m_data   <= data_byte;
        m_n      <= model_n(baud_set);
      end
    end
  end

  function automatic logic model_tx();
    int k;
    if (!m_active) return 1'b1;
    k = m_t / m_n;
    if (k == 0) return 1'b0;
    if (k <= 8) return m_data[k-1];
    return 1'b1;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Every wait goes through here so the model comparison sees every cycle.
  task automatic step();
    @(negedge Clk);
    cycle++;
    if (uart_state === 1'b1) busy_cycles++;
    if (Tx_Done === 1'b1) done_count++;
    check($sformatf("line@%0d", cycle), {31'd0, Rs232_Tx}, {31'd0, model_tx()});
    check($sformatf("busy@%0d", cycle), {31'd0, uart_state}, {31'd0, m_active});
    check($sformatf("done@%0d", cycle), {31'd0, Tx_Done}, {31'd0, m_done});
  endtask

  task automatic send_pulse(input logic [7:0] d, input logic [2:0] c);
    data_byte = d;
    baud_set  = c;
    send_en   = 1'b1;
    step();
    send_en   = 1'b0;
  endtask

  // Measures start-bit width and, when full, decodes the byte at mid-bit.
  task automatic rx_frame(input int n, input bit full, input bit mutate,
                          output logic [7:0] b, output int width);
    int g;
    g = 0;
    b = '0;
    width = 0;
    while (Rs232_Tx !== 1'b0 && g < 20000) begin step(); g++; end
    while (Rs232_Tx === 1'b0 && width < 20000) begin step(); width++; end
    if (full) begin
      repeat (n / 2) step();
      b[0] = Rs232_Tx;
      for (int i = 1; i < 8; i++) begin
        if (mutate && i == 3) begin
          data_byte = 8'h00;
          baud_set  = 3'd4;
        end
        repeat (n) step();
        b[i] = Rs232_Tx;
      end
    end
  endtask

  task automatic wait_done(input int bound, output bit ok);
    int g;
    g = 0;
    while (Tx_Done !== 1'b1 && g < bound) begin step(); g++; end
    ok = (Tx_Done === 1'b1);
  endtask

  task automatic async_reset(input string tag);
    #3 Rst = 1'b1;
    #1;
    check({tag, "_rst_line"}, {31'd0, Rs232_Tx}, 32'd1);
    check({tag, "_rst_busy"}, {31'd0, uart_state}, 32'd0);
    check({tag, "_rst_done"}, {31'd0, Tx_Done}, 32'd0);
    repeat (3) step();
    Rst = 1'b0;
    repeat (2) step();
  endtask

  initial begin
    logic [7:0] b;
    int         w;
    bit         ok;
    int         b0;
    int         d0;
    int         g;
    logic [2:0] codes [6] = '{3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd7};
    int         widths[6] = '{434, 868, 1302, 2604, 5208, 5208};
    bit         fulls [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

    // Reset and quiet idle
    repeat (10) step();
    check("reset_line", {31'd0, Rs232_Tx}, 32'd1);
    check("reset_busy", {31'd0, uart_state}, 32'd0);
    check("reset_done", {31'd0, Tx_Done}, 32'd0);
    Rst = 1'b0;
    repeat (100) step();
    check("idle_line", {31'd0, Rs232_Tx}, 32'd1);
    check("idle_busy", {31'd0, uart_state}, 32'd0);

    // Single frame 0x91 at 38400
    b0 = busy_cycles;
    d0 = done_count;
    send_pulse(8'h91, 3'd2);
    rx_frame(1302, 1'b1, 1'b0, b, w);
    check("f1_byte", {24'd0, b}, 32'h91);
    check("f1_width", w, 1302);
    wait_done(4000, ok);
    check("f1_done_seen", {31'd0, ok}, 32'd1);
    check("f1_busy_len", busy_cycles - b0, 13020);
    check("f1_done_cnt", done_count - d0, 1);
    repeat (2) step();

    // Baud sweep with 0x55; slow rates checked on start-bit width then aborted
    for (int i = 0; i < 6; i++) begin
      send_pulse(8'h55, codes[i]);
      rx_frame(widths[i], fulls[i], 1'b0, b, w);
      check($sformatf("sweep%0d_width", codes[i]), w, widths[i]);
      if (fulls[i]) begin
        check($sformatf("sweep%0d_byte", codes[i]), {24'd0, b}, 32'h55);
        wait_done(3 * widths[i], ok);
        check($sformatf("sweep%0d_done", codes[i]), {31'd0, ok}, 32'd1);
        repeat (2) step();
      end else begin
        async_reset($sformatf("sweep%0d", codes[i]));
      end
    end

    // Continuous request at 115200: three back-to-back frames
    b0 = busy_cycles;
    d0 = done_count;
    data_byte = 8'h91;
    baud_set  = 3'd4;
    send_en   = 1'b1;
    g = 0;
    while (done_count - d0 < 2 && g < 10000) begin step(); g++; end
    check("cont_two_done", done_count - d0, 2);
    repeat (5) step();
    send_en = 1'b0;
    g = 0;
    while (done_count - d0 < 3 && g < 6000) begin step(); g++; end
    repeat (300) step();
    check("cont_done_cnt", done_count - d0, 3);
    check("cont_busy_len", busy_cycles - b0, 13020);
    check("cont_end_line", {31'd0, Rs232_Tx}, 32'd1);
    check("cont_end_busy", {31'd0, uart_state}, 32'd0);

    // Inputs changed during DATA are ignored
    send_pulse(8'h91, 3'd2);
    rx_frame(1302, 1'b1, 1'b1, b, w);
    check("mid_byte", {24'd0, b}, 32'h91);
    check("mid_width", w, 1302);
    wait_done(4000, ok);
    check("mid_done_seen", {31'd0, ok}, 32'd1);
    repeat (2) step();

    // Reset during data bit 3, then a fresh frame
    d0 = done_count;
    send_pulse(8'h91, 3'd4);
    repeat (4 * 434 + 200) step();
    async_reset("abort");
    repeat (50) step();
    check("abort_no_done", done_count - d0, 0);
    send_pulse(8'h91, 3'd4);
    rx_frame(434, 1'b1, 1'b0, b, w);
    check("fresh_byte", {24'd0, b}, 32'h91);
    check("fresh_width", w, 434);
    wait_done(2000, ok);
    check("fresh_done_seen", {31'd0, ok}, 32'd1);
    repeat (5) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
